// File: rtl/fp_pkg.sv
// fp_pkg: shared 22-bit float format (1 sign, 5 exp, 16 frac).
// Exponent field 0 is zero; results truncate toward zero.
package fp_pkg;
  localparam int FP_W       = 22;
  localparam int FP_EXP_W   = 5;
  localparam int FP_FRAC_W  = 16;
  localparam int FP_MAN_W   = FP_FRAC_W + 1;
  localparam int FP_ADD_LAT = 3;

  typedef logic [FP_W-1:0] fp_t;
endpackage

// File: rtl/fp_add.sv
// fp_add: 3-stage float add/sub, all stages gated by i_en.
// Ports: clk, i_en, i_a, i_b, i_adsb (1 = a-b) -> o_c.
// Zero exponent flushes to 0, overflow saturates to max magnitude.
module fp_add
  import fp_pkg::*;
(
  input  logic clk,
  input  logic i_en,
  input  fp_t  i_a,
  input  fp_t  i_b,
  input  logic i_adsb,
  output fp_t  o_c
);
  // 32 guard bits exceed any alignment shift, so the sum is exact.
  localparam int XW = 32;
  localparam int AW = FP_MAN_W + XW;
  localparam int EMAX = (1 << FP_EXP_W) - 1;

  typedef logic [FP_EXP_W-1:0] exp_t;
  typedef logic [FP_MAN_W-1:0] man_t;

  exp_t ea, eb, big_e, sml_e, e1_q, e2_q;
  man_t ma, mb, big_m, sml_m, ma1_q;
  logic sb_eff, a_big;
  logic sg1_d, sub1_d, sg1_q, sub1_q, sg2_q;
  logic [AW-1:0] mb1_d, mb1_q;
  logic [AW:0] sum2_d, sum2_q;
  logic [5:0] lz;
  logic hit;
  int ne;
  fp_t c_d, c_q;

  assign ea = i_a[FP_W-2 -: FP_EXP_W];
  assign eb = i_b[FP_W-2 -: FP_EXP_W];
  assign ma = (ea == '0) ? '0 : {1'b1, i_a[FP_FRAC_W-1:0]};
  assign mb = (eb == '0) ? '0 : {1'b1, i_b[FP_FRAC_W-1:0]};
  assign sb_eff = i_b[FP_W-1] ^ i_adsb;
  // Larger magnitude goes first so subtraction never goes negative.
  assign a_big = i_a[FP_W-2:0] >= i_b[FP_W-2:0];

  always_comb begin
    big_e  = a_big ? ea : eb;
    sml_e  = a_big ? eb : ea;
    big_m  = a_big ? ma : mb;
    sml_m  = a_big ? mb : ma;
    sg1_d  = a_big ? i_a[FP_W-1] : sb_eff;
    sub1_d = i_a[FP_W-1] ^ sb_eff;
    mb1_d  = {sml_m, XW'(0)} >> (big_e - sml_e);
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      sg1_q  <= sg1_d;
      sub1_q <= sub1_d;
      e1_q   <= big_e;
      ma1_q  <= big_m;
      mb1_q  <= mb1_d;
    end
  end

  assign sum2_d = sub1_q ? ({1'b0, ma1_q, XW'(0)} - {1'b0, mb1_q})
                         : ({1'b0, ma1_q, XW'(0)} + {1'b0, mb1_q});

  always_ff @(posedge clk) begin
    if (i_en) begin
      sg2_q  <= sg1_q;
      e2_q   <= e1_q;
      sum2_q <= sum2_d;
    end
  end

  always_comb begin
    lz  = '0;
    hit = 1'b0;
    for (int i = AW; i >= 0; i--) begin
      if (!hit && sum2_q[i]) begin
        lz  = 6'(AW - i);
        hit = 1'b1;
      end
    end
    // Carry out (bit AW) means the exponent grows by one.
    ne = int'(e2_q) + 1 - int'(lz);
    if (!hit || ne < 1)
      c_d = '0;
    else if (ne > EMAX)
      c_d = {sg2_q, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b1}}};
    else
      c_d = {sg2_q, exp_t'(ne),
             FP_FRAC_W'((sum2_q << lz) >> (AW - FP_FRAC_W))};
  end

  always_ff @(posedge clk) begin
    if (i_en) c_q <= c_d;
  end

  assign o_c = c_q;
endmodule

// File: rtl/fp_add_arb.sv
// fp_add_arb: round-robin share of one fp_add among N_REQ ports.
// Ports: i_req/i_a/i_b/i_adsb in, o_gnt out; response o_rsp_valid/
// o_rsp_id/o_rsp_c with i_rsp_ready; o_busy = ops in flight.
module fp_add_arb
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int LAT   = FP_ADD_LAT
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*FP_W-1:0] i_a,
  input  logic [N_REQ*FP_W-1:0] i_b,
  input  logic [N_REQ-1:0]      i_adsb,
  output logic [N_REQ-1:0]      o_gnt,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output fp_t                   o_rsp_c,
  input  logic                  i_rsp_ready,
  output logic                  o_busy
);
  logic stall, en, gnt_vld, hit;
  int k;
  logic [ID_W-1:0] gidx, ptr_q, ptr_d;
  logic [LAT-1:0] v_q, v_d;
  logic [LAT-1:0][ID_W-1:0] id_q, id_d;
  fp_t op_a, op_b, add_c;
  logic op_sub;

  // A held response freezes the adder and every tag slot.
  assign stall = v_q[LAT-1] & ~i_rsp_ready;
  assign en    = ~stall;

  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    k    = 0;
    for (int j = 0; j < N_REQ; j++) begin
      k = (int'(ptr_q) + j) % N_REQ;
      if (!hit && i_req[k]) begin
        hit  = 1'b1;
        gidx = ID_W'(k);
      end
    end
    gnt_vld = hit & en & i_rst_n;
    o_gnt   = '0;
    if (gnt_vld) o_gnt[gidx] = 1'b1;
  end

  assign op_a   = gnt_vld ? i_a[gidx*FP_W +: FP_W] : '0;
  assign op_b   = gnt_vld ? i_b[gidx*FP_W +: FP_W] : '0;
  assign op_sub = gnt_vld & i_adsb[gidx];

  always_comb begin
    ptr_d = ptr_q;
    v_d   = v_q;
    id_d  = id_q;
    if (gnt_vld)
      ptr_d = (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    if (en) begin
      v_d  = {v_q[LAT-2:0], gnt_vld};
      id_d = {id_q[LAT-2:0], gidx};
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
      v_q   <= '0;
      id_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      v_q   <= v_d;
      id_q  <= id_d;
    end
  end

  fp_add u_add (
    .clk    (clk),
    .i_en   (en),
    .i_a    (op_a),
    .i_b    (op_b),
    .i_adsb (op_sub),
    .o_c    (add_c)
  );

  assign o_rsp_valid = v_q[LAT-1];
  assign o_rsp_id    = id_q[LAT-1];
  assign o_rsp_c     = v_q[LAT-1] ? add_c : '0;
  assign o_busy      = |v_q;
endmodule

// File: tb/tb_fp_add_arb.sv
// tb_fp_add_arb: scoreboard bench for fp_add_arb.
// Reference sum is computed on exact fixed-point values.
module tb_fp_add_arb;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0, adsb = '0, gnt;
  logic [87:0] a = '0, b = '0;
  logic rv, busy, rdy = 1'b1;
  logic [1:0] rid;
  fp_t rc;

  fp_add_arb #(.N_REQ(4)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_a(a), .i_b(b), .i_adsb(adsb), .o_gnt(gnt),
    .o_rsp_valid(rv), .o_rsp_id(rid), .o_rsp_c(rc),
    .i_rsp_ready(rdy), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { fp_t a; fp_t b; logic adsb; } op_t;
  typedef struct { int id; fp_t c; int gcyc; int gst; } sb_t;

  op_t pq[4][$];
  sb_t sb[$];
  int  glog[$];
  int  total = 0, bad = 0;
  int  cyc = 0, nstall = 0, tbptr = 0, rmode = 0;
  int  gcount[4];
  logic gnt_now = 1'b0, prev_stall = 1'b0;
  logic [24:0] prev_rsp = '0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Operand value scaled by 2^30, so every finite input is an integer.
  function automatic longint fxv(fp_t x);
    longint m;
    if (x[20:16] == 5'd0) return 0;
    m = longint'({1'b1, x[15:0]}) << (x[20:16] - 1);
    return x[21] ? -m : m;
  endfunction

  function automatic fp_t ref_add(fp_t x, fp_t y, logic sub);
    longint s;
    logic [63:0] mag;
    int p, e;
    logic sg;
    s = fxv(x) + (sub ? -fxv(y) : fxv(y));
    if (s == 0) return '0;
    sg  = s < 0;
    mag = sg ? -s : s;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = p - 15;
    if (e < 1) return '0;
    if (e > 31) return {sg, 5'h1f, 16'hffff};
    mag = mag >> (e - 1);
    return {sg, 5'(e), mag[15:0]};
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.a = fp_t'($urandom);
    if ($urandom_range(0, 7) == 0) o.a[20:16] = '0;
    o.b = fp_t'($urandom);
    case ($urandom_range(0, 7))
      0: o.b = o.a;
      1: o.b[20:16] = o.a[20:16];
      2: o.b[20:16] = '0;
      default: ;
    endcase
    o.adsb = 1'($urandom_range(0, 1));
    return o;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < 4; p++) n += pq[p].size();
    return n;
  endfunction

  task automatic push(int p, fp_t x, fp_t y, logic s);
    op_t o;
    o.a = x; o.b = y; o.adsb = s;
    pq[p].push_back(o);
  endtask

  task automatic step();
    logic [3:0] expg;
    int kk, idx;
    op_t o;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      req[p] = pq[p].size() > 0;
      a[p*22 +: 22] = req[p] ? pq[p][0].a : '0;
      b[p*22 +: 22] = req[p] ? pq[p][0].b : '0;
      adsb[p] = req[p] ? pq[p][0].adsb : 1'b0;
    end
    rdy = (rmode == 0) ? 1'b1 :
          (rmode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    #1;
    expg = '0;
    kk = -1;
    if (!(rv && !rdy)) begin
      for (int j = 0; j < 4; j++) begin
        idx = (tbptr + j) % 4;
        if (kk < 0 && req[idx]) kk = idx;
      end
    end
    if (kk >= 0) expg[kk] = 1'b1;
    chk("gnt", gnt, expg);
    gnt_now = kk >= 0;
    if (kk >= 0) begin
      o = pq[kk].pop_front();
      sb.push_back('{kk, ref_add(o.a, o.b, o.adsb), cyc, nstall});
      glog.push_back(kk);
      tbptr = (kk + 1) % 4;
      gcount[kk]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '1;
    for (int p = 0; p < 4; p++) pq[p].delete();
    sb.delete();
    glog.delete();
    tbptr = 0;
    gnt_now = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", rid, 0);
    chk("rst_c", rc, 0);
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic drain(string nm);
    int n = 0;
    rmode = 0;
    while ((pending() > 0 || sb.size() > 0) && n < 400) begin
      step();
      n++;
    end
    chk({nm, "_left"}, pending() + sb.size(), 0);
    step();
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("busy", busy, (sb.size() - (gnt_now ? 1 : 0)) > 0);
        if (!rv) chk("c_idle", rc, 0);
        if (prev_stall) chk("hold", {rv, rid, rc}, prev_rsp);
        if (rv && rdy) begin
          if (sb.size() == 0) chk("spurious", rv, 0);
          else begin
            e = sb.pop_front();
            chk("rsp_id", rid, e.id);
            chk("rsp_c", rc, e.c);
            chk("latency", cyc - e.gcyc, 3 + nstall - e.gst);
          end
        end
        prev_rsp = {rv, rid, rc};
        prev_stall = rv && !rdy;
        if (prev_stall) nstall++;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int order[4];
    int issued;

    // Saturation fairness: 0,1,2,3 repeating, 4 grants each.
    do_reset();
    for (int p = 0; p < 4; p++) gcount[p] = 0;
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < 4; p++) pq[p].push_back(rnd_op());
    drain("sat");
    for (int p = 0; p < 4; p++) chk("fair", gcount[p], 4);

    // Single issue on port 2, result visible three cycles later.
    do_reset();
    repeat (4) step();
    push(2, 22'h0F8000, 22'h0F8000, 1'b0);
    step();
    repeat (3) step();
    chk("si_valid", rv, 1);
    chk("si_id", rid, 2);
    chk("si_c", rc, 22'h108000);
    drain("si");

    // Pointer now at 3: ports 1 and 3 alternate starting at 3.
    glog.delete();
    push(1, 22'h0F0000, 22'h0E0000, 1'b1);
    push(1, 22'h2F1234, 22'h0F1234, 1'b0);
    push(3, 22'h110000, 22'h310000, 1'b0);
    push(3, 22'h1FFFFF, 22'h1FFFFF, 1'b0);
    drain("wrap");
    order = '{3, 1, 3, 1};
    chk("wrap_n", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("wrap_order", glog[i], order[i]);

    // Backpressure with a response presented and more requests queued.
    for (int p = 0; p < 3; p++) pq[p].push_back(rnd_op());
    issued = 0;
    while (!rv && issued < 20) begin step(); issued++; end
    chk("bp_valid", rv, 1);
    pq[3].push_back(rnd_op());
    pq[3].push_back(rnd_op());
    rmode = 2;
    repeat (5) step();
    drain("bp");

    // Reset with three operations in flight.
    for (int p = 0; p < 3; p++) pq[p].push_back(rnd_op());
    repeat (3) step();
    do_reset();
    repeat (6) step();
    chk("mid_valid", rv, 0);
    chk("mid_busy", busy, 0);
    pq[3].push_back(rnd_op());
    pq[0].push_back(rnd_op());
    drain("mid");
    chk("mid_first", glog.size() > 0 ? glog[0] : -1, 0);

    // Random soak with random consumer readiness.
    rmode = 1;
    issued = 0;
    while (issued < 10000) begin
      for (int p = 0; p < 4; p++) begin
        if (issued < 10000 && pq[p].size() == 0 &&
            $urandom_range(0, 1) == 1) begin
          pq[p].push_back(rnd_op());
          issued++;
        end
      end
      step();
    end
    drain("soak");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_arb.md
# fp_add_arb

Round-robin scheduler that shares one `fp_add` pipeline between `N_REQ` requesters, such as the vertex, raster and shading units. It accepts one add/sub per cycle from the highest-priority requesting port. It tags each operation with the requester ID through a valid/ID shift register that matches the adder latency, then returns the result with that ID on a single response port. Response backpressure freezes the whole adder pipeline through its `i_en`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `LAT`, default 3: `fp_add` latency in enabled cycles. Fixed by `fp_add`; not for user override.

- `clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req` in N_REQ: per-port request. Held high until granted.
- `i_a` in N_REQ*22: operand A, port k at bits [22k+21:22k].
- `i_b` in N_REQ*22: operand B, same packing as `i_a`.
- `i_adsb` in N_REQ: 0 = A+B, 1 = A−B.
- `o_gnt` in N_REQ? No: `o_gnt` out N_REQ. One-hot, combinational; operands are sampled in this cycle.
- `o_rsp_valid` out 1: result available.
- `o_rsp_id` out ID_W: requester that owns the result.
- `o_rsp_c` out 22: result. Forced to 0 while `o_rsp_valid`=0.
- `i_rsp_ready` in 1: consumer accepts the result this cycle.
- `o_busy` out 1: at least one operation in flight.

## Operation
- **Stall and enable.** `stall = o_rsp_valid & ~i_rsp_ready`. Adder enable is `en = ~stall`, wired to `fp_add.i_en`.
- **Arbitration.**
  - A grant is issued only when `en`=1 and `|i_req`.
  - The winner is the first requesting port at or after `ptr`, searching upward with wrap (k = ptr, ptr+1, …, N_REQ−1, 0, …).
  - On a grant to k, `ptr` ← (k+1) mod N_REQ. With no grant, `ptr` holds.
- **Operand mux.** The granted port's `i_a`/`i_b`/`i_adsb` drive the adder. With no grant, operands are 0 and the issued slot is a bubble.
- **Tag pipeline.** `v[0..LAT-1]` and `id[0..LAT-1]` shift together with the adder, only when `en`=1.
  - `v[0]` ← grant.
  - `id[0]` ← granted index.
  - `v[LAT-1]` and `id[LAT-1]` drive `o_rsp_valid` and `o_rsp_id`.
- **Result.** `o_rsp_c = v[LAT-1] ? fp_add.o_c : 0`.
- **Bubbles.** Bubbles are not collapsed. A stall freezes every slot, including empty ones.
- **Busy.** `o_busy = |v`.
- **Arithmetic.** Add/sub behaviour, rounding and normalization are exactly those of `fp_add`. The scheduler never modifies operands or results.

## Timing
- **Reset values.**
  - `v` = 0, `ptr` = 0.
  - `o_rsp_valid` = 0, `o_rsp_id` = 0, `o_rsp_c` = 0, `o_busy` = 0.
  - `o_gnt` = 0, because `i_req` has no effect while `v` is clear and the block is in reset.
- **Throughput.** With no stalls, one grant per cycle.
- **Latency.** A grant at cycle t produces `o_rsp_valid` at t+LAT, that is t+3.
- **Stall.** While `stall`=1:
  - `o_gnt` = 0.
  - `o_rsp_valid`, `o_rsp_id` and `o_rsp_c` are held stable.
  - `ptr` is held.
- **Handshake.** A response transfers on `o_rsp_valid & i_rsp_ready`. If the consumer is ready on the same cycle a new grant happens, both events occur with no gap.
- **Simultaneous requests.** The rotation is strictly fair: under saturation each port gets one grant per N_REQ grants.
- **Reset mid-operation.** `i_rst_n` low clears `v` immediately and asynchronously, and in-flight operations are dropped. `fp_add` data registers are not reset; their contents are masked by `v`.

## Structure
- **Shared package `fp_pkg`.**
  - `FP_W`=22, `FP_EXP_W`=5, `FP_FRAC_W`=16.
  - `FP_ADD_LAT`=3.
  - `typedef fp_t` (22-bit).
- **Sub-module.** One `fp_add` instance, named `u_add`, inside the block.
- **Inline logic.** Arbiter, operand mux and tag shift register are inline. A separate arbiter module is not justified at this size.

## Test plan
- **Single issue.** Reset; only port 2 requests `a`=22'h0F8000, `b`=22'h0F8000, `adsb`=0 at cycle 5 → `o_gnt`=4'b0100 at 5; `o_rsp_valid`=1, `o_rsp_id`=2 at cycle 8; `o_rsp_c` equals the standalone `fp_add` golden output.
- **Saturation fairness.** All 4 ports request continuously with `i_rsp_ready`=1 for 16 cycles → grant order 0,1,2,3,0,…; responses arrive 3 cycles after each grant in the same order, each port receiving 4.
- **Backpressure.** `i_rsp_ready`=0 for 5 cycles while a response is valid → `o_gnt`=0; `o_rsp_*` held constant; no response is lost or duplicated after `i_rsp_ready` returns to 1.
- **Pointer wrap and skip.** `ptr`=3, requests on ports 1 and 3 only → port 3 granted, then port 1, then port 3.
- **Reset mid-flight.** 3 operations in flight; pulse `i_rst_n` low for 1 cycle → `o_rsp_valid` stays 0 thereafter; `o_busy`=0; next grant goes to port 0.
- **Random soak.** 10k random requests with random `i_rsp_ready` → scoreboard (ID, result) matches the golden model in per-port order.
